// File: rtl/i2c_read_master.sv
// i2c_read_master: command-driven I2C read master. Issues START, addr+R, clocks in
// cmd_len bytes (ACK all but the last, NACK the last) and finishes with STOP.
module i2c_read_master #(
  parameter int CLK_DIV = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [3:0] cmd_len,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       nack,
  output logic       busy,
  inout  wire        SDA,
  inout  wire        SCL
);
  localparam int CW = 9;
  localparam logic [CW-1:0] Q1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] Q2 = CW'(2*CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, RX_BYTE, MACK, STOP} state_t;
  typedef enum logic [1:0] {L1, L2, H1, H2} phase_t;

  state_t        state, state_nxt;
  phase_t        phase, phase_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [3:0]    left, left_nxt;
  logic [6:0]    addr, addr_nxt;
  logic [7:0]    shift, shift_nxt, rx_data_nxt;
  logic          sda_oe, sda_oe_nxt, scl_oe, scl_oe_nxt;
  logic          rx_valid_nxt, done_nxt, nack_nxt;
  logic [1:0]    sda_sync, scl_sync;
  logic          sda_s, scl_s, cnt_zero;
  logic [7:0]    addr_byte;

  assign SDA       = sda_oe ? 1'b0 : 1'bz;
  assign SCL       = scl_oe ? 1'b0 : 1'bz;
  assign sda_s     = sda_sync[1];
  assign scl_s     = scl_sync[1];
  assign cnt_zero  = (cnt == '0);
  assign addr_byte = {addr, 1'b1};
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      sda_sync <= 2'b11;
      scl_sync <= 2'b11;
      state    <= IDLE;
      phase    <= L1;
      cnt      <= '0;
      bit_cnt  <= '0;
      left     <= '0;
      addr     <= '0;
      shift    <= '0;
      rx_data  <= '0;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      sda_sync <= {sda_sync[0], SDA};
      scl_sync <= {scl_sync[0], SCL};
      state    <= state_nxt;
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      left     <= left_nxt;
      addr     <= addr_nxt;
      shift    <= shift_nxt;
      rx_data  <= rx_data_nxt;
      sda_oe   <= sda_oe_nxt;
      scl_oe   <= scl_oe_nxt;
      rx_valid <= rx_valid_nxt;
      done     <= done_nxt;
      nack     <= nack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    cnt_nxt      = cnt - CW'(1);
    bit_cnt_nxt  = bit_cnt;
    left_nxt     = left;
    addr_nxt     = addr;
    shift_nxt    = shift;
    rx_data_nxt  = rx_data;
    sda_oe_nxt   = sda_oe;
    scl_oe_nxt   = scl_oe;
    rx_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    nack_nxt     = nack;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid) begin
          addr_nxt = cmd_addr;
          left_nxt = cmd_len;
          nack_nxt = 1'b0;
          if (cmd_len == 4'd0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = START;
            sda_oe_nxt = 1'b1;
            cnt_nxt    = Q2;
          end
        end
      end
      START: begin
        if (cnt_zero) begin
          state_nxt   = ADDR;
          phase_nxt   = L1;
          scl_oe_nxt  = 1'b1;
          cnt_nxt     = Q1;
          bit_cnt_nxt = 3'd7;
        end
      end
      default: begin
        // Every bit slot (and STOP) walks L1 -> L2 -> H1 -> H2.
        case (phase)
          L1: begin
            if (cnt_zero) begin
              phase_nxt = L2;
              cnt_nxt   = Q1;
              case (state)
                ADDR:    sda_oe_nxt = ~addr_byte[bit_cnt];
                MACK:    sda_oe_nxt = (left > 4'd1);
                STOP:    sda_oe_nxt = 1'b1;
                default: sda_oe_nxt = 1'b0;
              endcase
            end
          end
          L2: begin
            if (cnt_zero) begin
              phase_nxt  = H1;
              cnt_nxt    = Q1;
              scl_oe_nxt = 1'b0;
            end
          end
          H1: begin
            // High phase only counts once the synchronized SCL is really high.
            if (!scl_s) begin
              cnt_nxt = Q1;
            end else if (cnt_zero) begin
              phase_nxt = H2;
              cnt_nxt   = Q1;
              case (state)
                ADDR_ACK: nack_nxt = sda_s;
                RX_BYTE: begin
                  shift_nxt = {shift[6:0], sda_s};
                  if (bit_cnt == 3'd0) begin
                    rx_data_nxt  = {shift[6:0], sda_s};
                    rx_valid_nxt = 1'b1;
                  end
                end
                STOP: begin
                  sda_oe_nxt = 1'b0;
                  cnt_nxt    = Q2;
                end
                default: ;
              endcase
            end
          end
          H2: begin
            if (cnt_zero) begin
              phase_nxt  = L1;
              cnt_nxt    = Q1;
              scl_oe_nxt = 1'b1;
              case (state)
                ADDR: begin
                  if (bit_cnt == 3'd0) state_nxt = ADDR_ACK;
                  else bit_cnt_nxt = bit_cnt - 3'd1;
                end
                ADDR_ACK: begin
                  state_nxt   = nack ? STOP : RX_BYTE;
                  bit_cnt_nxt = 3'd7;
                end
                RX_BYTE: begin
                  if (bit_cnt == 3'd0) state_nxt = MACK;
                  else bit_cnt_nxt = bit_cnt - 3'd1;
                end
                MACK: begin
                  if (left > 4'd1) begin
                    left_nxt    = left - 4'd1;
                    state_nxt   = RX_BYTE;
                    bit_cnt_nxt = 3'd7;
                  end else begin
                    state_nxt = STOP;
                  end
                end
                default: begin
                  state_nxt  = IDLE;
                  cnt_nxt    = '0;
                  scl_oe_nxt = 1'b0;
                  done_nxt   = 1'b1;
                end
              endcase
            end
          end
        endcase
      end
    endcase
  end
endmodule

// File: tb/tb_i2c_read_master.sv
// tb_i2c_read_master: directed bench with a behavioral I2C slave at 0x11 that
// returns 0x33 for every byte and can stretch SCL during address bit 3.
module tb_i2c_read_master;
  localparam int Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       cmd_ready, rx_valid, done, nack, busy;
  logic [7:0] rx_data;
  wire        SDA, SCL;

  pullup pu_sda (SDA);
  pullup pu_scl (SCL);

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  i2c_read_master #(.CLK_DIV(Q)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rx_data(rx_data), .rx_valid(rx_valid),
    .done(done), .nack(nack), .busy(busy), .SDA(SDA), .SCL(SCL)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioral slave; it is reset with the DUT so the bus is quiet after reset.
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACK, S_TX, S_MACK} sst_t;
  sst_t       sst = S_IDLE;
  logic       s_sda_low = 1'b0, s_scl_low = 1'b0;
  logic       p_sda = 1'b1, p_scl = 1'b1;
  logic [7:0] sh = '0, tx_sh = '0;
  logic [7:0] slv_data = 8'h33;
  logic       m_ack = 1'b0;
  logic       stretch_en = 1'b0;
  int         bitn = 0, txb = 0, scnt = 0;
  int         macks = 0, mnacks = 0;

  assign SDA = s_sda_low ? 1'b0 : 1'bz;
  assign SCL = s_scl_low ? 1'b0 : 1'bz;

  always @(posedge clock) begin
    p_sda <= SDA;
    p_scl <= SCL;
    if (reset) begin
      sst       <= S_IDLE;
      s_sda_low <= 1'b0;
      s_scl_low <= 1'b0;
    end else begin
      if (s_scl_low) begin
        scnt <= scnt - 1;
        if (scnt == 1) s_scl_low <= 1'b0;
      end
      if (p_scl && SCL && p_sda && !SDA) begin
        sst       <= S_ADDR;
        bitn      <= 0;
        s_sda_low <= 1'b0;
      end else if (p_scl && SCL && !p_sda && SDA) begin
        sst       <= S_IDLE;
        s_sda_low <= 1'b0;
      end else if (!p_scl && SCL) begin
        case (sst)
          S_ADDR: begin
            sh   <= {sh[6:0], SDA};
            bitn <= bitn + 1;
          end
          S_MACK: begin
            if (SDA) mnacks <= mnacks + 1;
            else macks <= macks + 1;
            m_ack <= !SDA;
          end
          default: ;
        endcase
      end else if (p_scl && !SCL) begin
        case (sst)
          S_ADDR: begin
            if (bitn == 8) begin
              if (sh == {7'h11, 1'b1}) begin
                s_sda_low <= 1'b1;
                sst       <= S_ACK;
              end else begin
                sst <= S_IDLE;
              end
            end else if (bitn == 3 && stretch_en) begin
              // Master releases SCL 2Q after this fall; hold 50 clocks beyond that.
              s_scl_low <= 1'b1;
              scnt      <= 2*Q + 49;
            end
          end
          S_ACK, S_MACK: begin
            if (sst == S_ACK || m_ack) begin
              s_sda_low <= !slv_data[7];
              tx_sh     <= slv_data << 1;
              txb       <= 1;
              sst       <= S_TX;
            end else begin
              s_sda_low <= 1'b0;
              sst       <= S_IDLE;
            end
          end
          S_TX: begin
            if (txb == 8) begin
              s_sda_low <= 1'b0;
              sst       <= S_MACK;
            end else begin
              s_sda_low <= !tx_sh[7];
              tx_sh     <= tx_sh << 1;
              txb       <= txb + 1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bus and output monitors.
  int         scl_rises = 0, stops = 0, low_seen = 0, rx_cnt = 0, done_cnt = 0;
  logic [7:0] rx_log [0:63];

  always @(posedge clock) begin
    if (!p_scl && SCL) scl_rises <= scl_rises + 1;
    if (p_scl && SCL && !p_sda && SDA) stops <= stops + 1;
    if (SDA !== 1'b1 || SCL !== 1'b1) low_seen <= low_seen + 1;
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_cmd(input logic [6:0] a, input logic [3:0] n, output int cyc);
    @(negedge clock);
    cmd_addr  = a;
    cmd_len   = n;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_done(cyc);
  endtask

  // Accept-to-done latency in clocks: START 2Q, 4Q+2 per bit slot, STOP 5Q+2.
  function automatic int lat(input int bits);
    return 2*Q + bits*(4*Q + 2) + 5*Q + 2;
  endfunction

  initial begin
    int cyc, r0, sr0, st0, a0, n0, d0, l0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ctl", {cmd_ready, busy, rx_valid, done, nack}, 5'b10000);
    chk("rst_rxdata", rx_data, 8'h00);
    chk("rst_bus", {SDA, SCL}, 2'b11);

    // Two-byte read from 0x11.
    r0 = rx_cnt; sr0 = scl_rises; st0 = stops; a0 = macks; n0 = mnacks; d0 = done_cnt;
    run_cmd(7'h11, 4'd2, cyc);
    chk("t1_latency", cyc, lat(27));
    chk("t1_nack", nack, 1'b0);
    chk("t1_ready_busy", {cmd_ready, busy}, 2'b10);
    repeat (3) @(negedge clock);
    chk("t1_rx_count", rx_cnt - r0, 2);
    chk("t1_byte0", rx_log[6'(r0)], 8'h33);
    chk("t1_byte1", rx_log[6'(r0 + 1)], 8'h33);
    chk("t1_acks", macks - a0, 1);
    chk("t1_nacks", mnacks - n0, 1);
    chk("t1_stops", stops - st0, 1);
    chk("t1_scl_rises", scl_rises - sr0, 28);
    chk("t1_done_once", done_cnt - d0, 1);

    // Unanswered address: NACK, no data, STOP after the 9th clock.
    r0 = rx_cnt; sr0 = scl_rises; st0 = stops;
    run_cmd(7'h12, 4'd3, cyc);
    chk("t2_latency", cyc, lat(9));
    chk("t2_nack", nack, 1'b1);
    repeat (3) @(negedge clock);
    chk("t2_nack_held", nack, 1'b1);
    chk("t2_rx_count", rx_cnt - r0, 0);
    chk("t2_scl_rises", scl_rises - sr0, 10);
    chk("t2_stops", stops - st0, 1);

    // Zero-length command: done right after accept, bus untouched.
    l0 = low_seen; d0 = done_cnt;
    run_cmd(7'h11, 4'd0, cyc);
    chk("t3_latency", cyc, 0);
    chk("t3_nack", nack, 1'b0);
    repeat (5) @(negedge clock);
    chk("t3_bus_quiet", low_seen - l0, 0);
    chk("t3_done_once", done_cnt - d0, 1);

    // Slave stretches SCL during address bit 3.
    r0 = rx_cnt;
    stretch_en = 1'b1;
    run_cmd(7'h11, 4'd1, cyc);
    stretch_en = 1'b0;
    chk("t4_latency", cyc, lat(18) + 50);
    @(negedge clock);
    chk("t4_rx_count", rx_cnt - r0, 1);
    chk("t4_byte", rx_log[6'(r0)], 8'h33);

    // Reset in the middle of the 4th data bit.
    r0 = rx_cnt;
    @(negedge clock);
    cmd_addr = 7'h11; cmd_len = 4'd2; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (2*Q + 9*(4*Q+2) + 3*(4*Q+2) + 2*Q + 1) @(negedge clock);
    chk("t5_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_bus_released", {SDA, SCL}, 2'b11);
    chk("t5_ctl", {cmd_ready, busy, rx_valid, done, nack}, 5'b10000);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clock);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_rx", rx_cnt - r0, 0);
    run_cmd(7'h11, 4'd1, cyc);
    chk("t5_after_latency", cyc, lat(18));
    @(negedge clock);
    chk("t5_after_byte", rx_log[6'(r0)], 8'h33);

    // cmd_valid held through the transaction with a different address.
    r0 = rx_cnt; sr0 = scl_rises;
    @(negedge clock);
    cmd_addr = 7'h11; cmd_len = 4'd1; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_addr = 7'h12; cmd_len = 4'd3;
    wait_done(cyc);
    cmd_valid = 1'b0;
    chk("t6_latency", cyc, lat(18));
    chk("t6_ready_with_done", cmd_ready, 1'b1);
    chk("t6_nack", nack, 1'b0);
    repeat (3) @(negedge clock);
    chk("t6_idle", {cmd_ready, busy}, 2'b10);
    chk("t6_rx_count", rx_cnt - r0, 1);
    chk("t6_byte", rx_log[6'(r0)], 8'h33);
    chk("t6_scl_rises", scl_rises - sr0, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_read_master.md
# i2c_read_master

Command-driven I2C master that sequences read transactions on the shared open-drain SDA/SCL bus against the team's I2C slave blocks (e.g. the 7-bit-addressed slave at 0x11 that returns its buffer byte). It accepts a command (7-bit address, byte count), generates START, address+R, samples the ACK, clocks in N bytes, ACKs all but the last, NACKs the last, and issues STOP. It sits between host-side control logic and the I2C pads, and is the block that drives SCL for every slave on the bus.

## Interface
- CLK_DIV, 8: system clocks per SCL quarter-period Q; legal range 4..255.
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  high when idle and able to accept a command
- cmd_addr  input  7  target slave address
- cmd_len  input  4  bytes to read, 0..15
- rx_data  output  8  last received byte
- rx_valid  output  1  one-cycle pulse, rx_data updated this cycle
- done  output  1  one-cycle pulse at end of command
- nack  output  1  address NACKed on last command; valid with done, held until next accept
- busy  output  1  command in progress
- SDA  inout  1  open-drain data, driven 0 or released (z)
- SCL  inout  1  open-drain clock, driven 0 or released (z)

## Operation
- Reset: SDA/SCL released, cmd_ready=1, busy=0, rx_valid=0, done=0, nack=0, rx_data=0x00, state IDLE, synchronizers set to 1.
- SDA and SCL inputs pass through a 2-flop synchronizer before any use.
- Accept on cmd_valid && cmd_ready: latch addr/len, clear nack, cmd_ready=0, busy=1. cmd_valid while busy is ignored.
- cmd_len=0: no bus activity; done pulses the cycle after accept, nack=0.
- States: IDLE -> START -> ADDR (8 bits: addr[6:0] MSB first, then R/W=1) -> ADDR_ACK -> RX_BYTE -> MACK -> (RX_BYTE | STOP) -> IDLE.
- ADDR_ACK: master releases SDA, samples. Sampled 1 -> nack=1, go STOP. Sampled 0 -> RX_BYTE.
- RX_BYTE: master releases SDA, samples 8 bits MSB first into shift register; after 8th sample rx_data<=shift, rx_valid pulse.
- MACK: drive SDA 0 if bytes remaining >1 (ACK), release if last byte (NACK); then RX_BYTE or STOP.
- STOP: SDA driven low during SCL low, SCL released, then SDA released while SCL high; then bus-free wait; done pulses, busy=0, cmd_ready=1.
- Clock stretching: whenever master releases SCL it waits until synchronized SCL reads 1 before counting the high phase; no upper bound.
- Reset mid-transaction: both lines released the cycle after reset is sampled; no STOP generated; outputs return to reset values.

## Timing
- Q = CLK_DIV clocks, counted by a down-counter reloaded on every phase change.
- START: SDA driven low with SCL high, hold 2Q, then SCL driven low.
- Each bit (address, ACK, data, MACK), 4 phases: L1 (Q, SCL low, SDA held), SDA updated at start of L2 (Q, SCL low), H1 (SCL released; count Q after synced SCL=1; sample synced SDA at end), H2 (Q high), then SCL driven low.
- Each SCL rise costs 4Q+2 clocks per bit without stretching (2 = synchronizer latency).
- STOP: 2Q SCL low with SDA low, SCL released, Q after synced high SDA released, 2Q bus-free, then done.
- rx_valid asserts the cycle after the 8th bit's sample; done never coincides with rx_valid.
- No SDA transition while SCL is high except START and STOP.

## Test plan
- Read slave 0x11, len=2, CLK_DIV=8 -> two rx_valid pulses with rx_data=0x33, 0x33; nack=0; first byte ACKed, second NACKed, STOP on bus, done once.
- Read addr 0x12, len=3 -> nack=1 at done, zero rx_valid pulses, STOP generated after 9th clock.
- cmd_len=0 -> done the cycle after accept, nack=0, SDA/SCL never driven low.
- Bench holds SCL low 50 clocks after master release in bit 3 of address -> high phase extends, sample taken Q clocks after SCL returns high, transaction completes with 0x33.
- Assert reset during 4th data bit -> SDA/SCL high-z next cycle, cmd_ready=1, busy=0, no done pulse; new command afterwards completes normally.
- cmd_valid held high while busy with differing addr -> ignored; only first command's bytes returned; cmd_ready rises with done.
